// File: rtl/spdif_subframe_deframer_pkg.sv
// Purpose : shared symbol encodings and framing constants for the S/PDIF subframe deframer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package spdif_subframe_deframer_pkg;

  // Symbol kinds delivered by the biphase/preamble decoder.
  localparam logic [1:0] SYM_DATA = 2'd0;
  localparam logic [1:0] SYM_B    = 2'd1;
  localparam logic [1:0] SYM_M    = 2'd2;
  localparam logic [1:0] SYM_W    = 2'd3;

  localparam int SUBFRAME_BITS    = 28;   // 24 audio + V + U + C + P
  localparam int FRAMES_PER_BLOCK = 192;  // channel-status block length
  localparam int BITCNT_W         = 5;
  localparam int FRAME_W          = 8;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/spdif_cstat_collector.sv
// Purpose : assembles the 192-bit channel-status block from channel-A C bits and publishes it.
// Latency : o_cstat/o_cstat_valid update 1 clk after i_copy; the bit written in the copy cycle is included.
// Backpr. : none; one write per cycle at most, accepted unconditionally.
// Ports   : i_clk/i_rst sync reset; i_wr_en/i_wr_idx/i_wr_bit write one shadow bit;
//           i_clear wipes the shadow (lock loss); i_copy publishes shadow to o_cstat, pulsing o_cstat_valid.
module spdif_cstat_collector
  import spdif_subframe_deframer_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [FRAME_W-1:0]          i_wr_idx,
  input  logic                        i_wr_bit,
  input  logic                        i_clear,
  input  logic                        i_copy,
  output logic [FRAMES_PER_BLOCK-1:0] o_cstat,
  output logic                        o_cstat_valid
);

  logic [FRAMES_PER_BLOCK-1:0] r_shadow;
  logic [FRAMES_PER_BLOCK-1:0] r_cstat;
  logic                        r_cstat_valid;
  logic [FRAMES_PER_BLOCK-1:0] w_shadow_next;

  // Clear has priority: a subframe that breaks lock must not leave its C bit behind.
  always_comb begin
    w_shadow_next = r_shadow;
    if (i_clear) begin
      w_shadow_next = '0;
    end else if (i_wr_en && (i_wr_idx <= FRAME_W'(FRAMES_PER_BLOCK - 1))) begin
      w_shadow_next[i_wr_idx] = i_wr_bit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow      <= '0;
      r_cstat       <= '0;
      r_cstat_valid <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_next;
      r_cstat_valid <= i_copy;
      // Copy the post-write view so frame 191's own C bit lands in the block.
      if (i_copy) begin
        r_cstat <= w_shadow_next;
      end
    end
  end

  assign o_cstat       = r_cstat;
  assign o_cstat_valid = r_cstat_valid;

endmodule

// File: rtl/spdif_subframe_deframer.sv
// Purpose : turns decoded S/PDIF symbols into 24-bit L/R samples with parity, sequencing, lock and channel status.
// Latency : sample_* / lock / cstat_* registered, valid 1 clk after the 28th data bit of a subframe.
// Backpr. : none; a symbol is consumed on every i_sym_valid cycle, outputs are single-cycle pulses.
// Ports   : i_clk, i_rst (sync, active high); i_sym_valid/i_sym_kind/i_sym_bit symbol input;
//           o_sample_* sample word and side info; o_parity_err; o_lock; o_cstat/o_cstat_valid.
module spdif_subframe_deframer
  import spdif_subframe_deframer_pkg::*;
#(
  parameter int LOCK_COUNT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_sym_valid,
  input  logic [1:0]                  i_sym_kind,
  input  logic                        i_sym_bit,
  output logic                        o_sample_valid,
  output logic [23:0]                 o_sample_data,
  output logic                        o_sample_right,
  output logic                        o_sample_blk_start,
  output logic [2:0]                  o_sample_vuc,
  output logic                        o_parity_err,
  output logic                        o_lock,
  output logic [FRAMES_PER_BLOCK-1:0] o_cstat,
  output logic                        o_cstat_valid
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_BLOCK - 1);

  state_t              r_state, w_state_next;
  logic [BITCNT_W-1:0] r_bitcnt;
  logic [26:0]         r_shift;
  logic                r_right;       // side of subframe being collected
  logic                r_blk;         // subframe being collected started with B
  logic                r_seq_err;     // its preamble broke the sequencing rules
  logic                r_seq_ok;      // previous subframe completed cleanly enough to check against
  logic                r_prev_right;  // side of last completed subframe
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic                r_lock;

  logic                r_sample_valid;
  logic [23:0]         r_sample_data;
  logic                r_sample_right;
  logic                r_sample_blk_start;
  logic [2:0]          r_sample_vuc;
  logic                r_parity_err;

  logic                w_is_pre, w_is_data, w_done, w_trunc;
  logic [27:0]         w_full;
  logic                w_perr, w_err, w_seq_err, w_lock_next;
  logic [FRAME_W-1:0]  w_frame_next;
  logic [LOCK_W-1:0]   w_lock_cnt_next;

  assign w_is_pre  = i_sym_valid && (i_sym_kind != SYM_DATA);
  assign w_is_data = i_sym_valid && (i_sym_kind == SYM_DATA);
  assign w_done    = (r_state == ST_COLLECT) && w_is_data
                     && (r_bitcnt == BITCNT_W'(SUBFRAME_BITS - 1));
  assign w_trunc   = (r_state == ST_COLLECT) && w_is_pre;
  assign w_full    = {i_sym_bit, r_shift};
  assign w_perr    = ^w_full;
  assign w_err     = w_perr || r_seq_err;

  // Preamble checks only apply when the previous subframe ended normally; a B closes a
  // block only from frame 191, an M may never push the frame index to 192.
  always_comb begin
    w_seq_err = 1'b0;
    if (r_seq_ok && (r_state == ST_HUNT) && w_is_pre) begin
      if (i_sym_kind == SYM_W) begin
        w_seq_err = r_prev_right;
      end else if (i_sym_kind == SYM_B) begin
        w_seq_err = !r_prev_right || (r_frame_cnt != LAST_FRAME);
      end else begin
        w_seq_err = !r_prev_right || (r_frame_cnt == LAST_FRAME);
      end
    end
  end

  always_comb begin
    w_frame_next = r_frame_cnt;
    if (w_is_pre) begin
      if (i_sym_kind == SYM_B) begin
        w_frame_next = '0;
      end else if (i_sym_kind == SYM_M) begin
        w_frame_next = (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    w_lock_cnt_next = r_lock_cnt;
    if (w_trunc) begin
      w_lock_cnt_next = '0;
    end else if (w_done) begin
      if (w_err) begin
        w_lock_cnt_next = '0;
      end else if (r_lock_cnt != LOCK_W'(LOCK_COUNT)) begin
        w_lock_cnt_next = r_lock_cnt + LOCK_W'(1);
      end
    end
  end
  assign w_lock_next = (w_lock_cnt_next == LOCK_W'(LOCK_COUNT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT:    if (w_is_pre) w_state_next = ST_COLLECT;
      ST_COLLECT: if (w_done)   w_state_next = ST_HUNT;
      default:    w_state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitcnt           <= '0;
      r_shift            <= '0;
      r_right            <= 1'b0;
      r_blk              <= 1'b0;
      r_seq_err          <= 1'b0;
      r_seq_ok           <= 1'b0;
      r_prev_right       <= 1'b0;
      r_frame_cnt        <= '0;
      r_lock_cnt         <= '0;
      r_lock             <= 1'b0;
      r_sample_valid     <= 1'b0;
      r_sample_data      <= '0;
      r_sample_right     <= 1'b0;
      r_sample_blk_start <= 1'b0;
      r_sample_vuc       <= '0;
      r_parity_err       <= 1'b0;
    end else begin
      r_sample_valid <= w_done;
      r_lock_cnt     <= w_lock_cnt_next;
      r_lock         <= w_lock_next;
      r_frame_cnt    <= w_frame_next;

      if (w_is_pre) begin
        r_bitcnt  <= '0;
        r_right   <= (i_sym_kind == SYM_W);
        r_blk     <= (i_sym_kind == SYM_B);
        r_seq_err <= w_seq_err;
      end
      // The preamble that cut a subframe short has nothing to be checked against.
      if (w_trunc) begin
        r_seq_ok <= 1'b0;
      end

      if ((r_state == ST_COLLECT) && w_is_data && !w_done) begin
        r_shift[r_bitcnt] <= i_sym_bit;
        r_bitcnt          <= r_bitcnt + BITCNT_W'(1);
      end

      if (w_done) begin
        r_sample_data      <= w_full[23:0];
        r_sample_right     <= r_right;
        r_sample_blk_start <= r_blk;
        r_sample_vuc       <= {w_full[24], w_full[25], w_full[26]};
        r_parity_err       <= w_perr;
        r_prev_right       <= r_right;
        // After a sequencing error the next preamble starts a fresh reference.
        r_seq_ok           <= !r_seq_err;
      end
    end
  end

  spdif_cstat_collector u_cstat (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (w_done && !r_right),
    .i_wr_idx      (r_frame_cnt),
    .i_wr_bit      (w_full[26]),
    .i_clear       (w_trunc || (w_done && w_err)),
    .i_copy        (w_done && !r_right && (r_frame_cnt == LAST_FRAME) && w_lock_next),
    .o_cstat       (o_cstat),
    .o_cstat_valid (o_cstat_valid)
  );

  assign o_sample_valid     = r_sample_valid;
  assign o_sample_data      = r_sample_data;
  assign o_sample_right     = r_sample_right;
  assign o_sample_blk_start = r_sample_blk_start;
  assign o_sample_vuc       = r_sample_vuc;
  assign o_parity_err       = r_parity_err;
  assign o_lock             = r_lock;

endmodule

// File: tb/tb_spdif_subframe_deframer.sv
// Scoreboard bench: stimulus pushes hand-derived expected samples, a forked monitor pops and compares.
module tb_spdif_subframe_deframer;
  import spdif_subframe_deframer_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_sym_valid = 1'b0;
  logic [1:0]   i_sym_kind = 2'd0;
  logic         i_sym_bit = 1'b0;
  logic         o_sample_valid;
  logic [23:0]  o_sample_data;
  logic         o_sample_right;
  logic         o_sample_blk_start;
  logic [2:0]   o_sample_vuc;
  logic         o_parity_err;
  logic         o_lock;
  logic [191:0] o_cstat;
  logic         o_cstat_valid;

  spdif_subframe_deframer #(.LOCK_COUNT(4)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_sym_valid        (i_sym_valid),
    .i_sym_kind         (i_sym_kind),
    .i_sym_bit          (i_sym_bit),
    .o_sample_valid     (o_sample_valid),
    .o_sample_data      (o_sample_data),
    .o_sample_right     (o_sample_right),
    .o_sample_blk_start (o_sample_blk_start),
    .o_sample_vuc       (o_sample_vuc),
    .o_parity_err       (o_parity_err),
    .o_lock             (o_lock),
    .o_cstat            (o_cstat),
    .o_cstat_valid      (o_cstat_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [23:0] data;
    logic        right;
    logic        blk;
    logic [2:0]  vuc;
    logic        perr;
    logic        lock;
    logic        cv;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cv_seen = 0;
  logic [191:0] exp_cstat = '0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sym(input logic [1:0] k, input logic b);
    i_sym_valid = 1'b1;
    i_sym_kind  = k;
    i_sym_bit   = b;
    @(posedge i_clk);
    #1;
    i_sym_valid = 1'b0;
    i_sym_kind  = SYM_DATA;
    i_sym_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Queue the expected sample then send the 28 data bits; P makes the subframe even
  // unless bad_par flips it.
  task automatic body(input logic [1:0] k, input logic [23:0] d, input logic [2:0] vuc,
                      input logic bad_par, input logic exp_lock, input logic exp_cv, input int gap);
    logic [27:0] w;
    exp_t e;
    w = {1'b0, vuc[0], vuc[1], vuc[2], d};
    w[27] = (^w[26:0]) ^ bad_par;
    e.data = d; e.right = (k == SYM_W); e.blk = (k == SYM_B); e.vuc = vuc;
    e.perr = bad_par; e.lock = exp_lock; e.cv = exp_cv;
    q.push_back(e);
    for (int i = 0; i < 28; i++) begin
      sym(SYM_DATA, w[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic subframe(input logic [1:0] k, input logic [23:0] d, input logic [2:0] vuc,
                          input logic bad_par, input logic exp_lock, input logic exp_cv, input int gap);
    sym(k, 1'b0);
    body(k, d, vuc, bad_par, exp_lock, exp_cv, gap);
  endtask

  task automatic drain(input string name);
    idle(3);
    check(name, 192'(q.size()), 192'd0);
  endtask

  task automatic pulse_rst();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge i_clk);
        if (o_cstat_valid) cv_seen++;
        if (o_sample_valid) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample: got data %0h with no expected entry", o_sample_data);
          end else begin
            e = q.pop_front();
            check("sample_data",  192'(o_sample_data),      192'(e.data));
            check("sample_right", 192'(o_sample_right),     192'(e.right));
            check("blk_start",    192'(o_sample_blk_start), 192'(e.blk));
            check("sample_vuc",   192'(o_sample_vuc),       192'(e.vuc));
            check("parity_err",   192'(o_parity_err),       192'(e.perr));
            check("lock",         192'(o_lock),             192'(e.lock));
            check("cstat_valid",  192'(o_cstat_valid),      192'(e.cv));
            if (e.cv) check("cstat", o_cstat, exp_cstat);
          end
        end else if (o_cstat_valid) begin
          checks++;
          failures++;
          $display("FAIL cstat_valid_alone: got 1 expected 0");
        end
      end
    join_none

    // Reset state
    idle(3);
    i_rst = 1'b0;
    idle(1);
    check("rst_sample_valid", 192'(o_sample_valid), 192'd0);
    check("rst_sample_data",  192'(o_sample_data),  192'd0);
    check("rst_lock",         192'(o_lock),         192'd0);
    check("rst_cstat",        o_cstat,              192'd0);
    check("rst_cstat_valid",  192'(o_cstat_valid),  192'd0);

    // Basic L/R, sparse then back-to-back; lock after the 4th clean subframe
    subframe(SYM_B, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0, 1);
    subframe(SYM_W, 24'h000001, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_M, 24'h123456, 3'b100, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_W, 24'hABCDEF, 3'b010, 1'b0, 1'b1, 1'b0, 0);

    // Truncated subframe: M after 10 data bits, lock drops immediately
    sym(SYM_M, 1'b0);
    for (int i = 0; i < 10; i++) sym(SYM_DATA, 1'b1);
    sym(SYM_M, 1'b0);
    check("trunc_lock", 192'(o_lock), 192'd0);
    body(SYM_M, 24'h00F00F, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_W, 24'h800000, 3'b000, 1'b0, 1'b0, 1'b0, 0);

    // Parity failure: data 0, VUC=111, P=0
    subframe(SYM_M, 24'h000000, 3'b111, 1'b1, 1'b0, 1'b0, 0);
    subframe(SYM_W, 24'h000010, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_M, 24'h000020, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_W, 24'h000030, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_M, 24'h000040, 3'b000, 1'b0, 1'b1, 1'b0, 0);

    // W after W: second sample still emitted, lock cleared; next M is not checked
    subframe(SYM_W, 24'h5A5A5A, 3'b000, 1'b0, 1'b1, 1'b0, 0);
    subframe(SYM_W, 24'hA5A5A5, 3'b001, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_M, 24'h0F0F0F, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    drain("drain_directed");

    // Reset mid-subframe at bit 15
    sym(SYM_B, 1'b0);
    for (int i = 0; i < 15; i++) sym(SYM_DATA, i[0]);
    pulse_rst();
    idle(2);
    check("midrst_sample_data", 192'(o_sample_data),  192'd0);
    check("midrst_sample_vuc",  192'(o_sample_vuc),   192'd0);
    check("midrst_lock",        192'(o_lock),         192'd0);
    check("midrst_valid",       192'(o_sample_valid), 192'd0);
    subframe(SYM_B, 24'h654321, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    subframe(SYM_W, 24'h0000FF, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    drain("drain_rst");

    // Full 192-frame block, C=1 on frames 0 and 191
    pulse_rst();
    exp_cstat = '0;
    exp_cstat[0] = 1'b1;
    exp_cstat[191] = 1'b1;
    cv_seen = 0;
    for (int f = 0; f < 192; f++) begin
      logic [23:0] d;
      logic        c;
      d = 24'(f * 24'h010203 + 7);
      c = (f == 0) || (f == 191);
      subframe((f == 0) ? SYM_B : SYM_M, d, {2'b00, c}, 1'b0, (2 * f) >= 3, f == 191, 0);
      subframe(SYM_W, ~d, 3'b000, 1'b0, (2 * f + 1) >= 3, 1'b0, 0);
    end
    subframe(SYM_B, 24'h111111, 3'b001, 1'b0, 1'b1, 1'b0, 0);
    subframe(SYM_W, 24'h222222, 3'b000, 1'b0, 1'b1, 1'b0, 0);
    drain("drain_block");
    check("cstat_hold", o_cstat, {1'b1, 190'd0, 1'b1});
    check("cstat_valid_count", 192'(cv_seen), 192'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
